// File: rtl/ram_stream_reader_if.sv
// Valid/ready byte stream carrying words read out of the RAM.
// The master drives data/valid; the slave drives ready.
interface ram_stream_reader_if #(
  parameter int DW = 8
) ();
  logic [DW-1:0] data;
  logic          valid;
  logic          ready;

  modport master (
    output data,
    output valid,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    output ready
  );
endinterface

// File: rtl/ram_stream_reader.sv
// Streams a block of RAM words, base upward with wrap, onto a valid/ready
// output, hiding the 1-cycle RAM latency behind a 2-entry buffer.
module ram_stream_reader #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  input  logic [ADDR_WIDTH:0]   i_length,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic                  o_ram_we,
  input  logic [DATA_WIDTH-1:0] i_ram_q,
  ram_stream_reader_if.master   o_strm
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    FINISH
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [ADDR_WIDTH-1:0] r_base;
  logic [ADDR_WIDTH-1:0] r_last_addr;
  logic [ADDR_WIDTH:0]   r_len;
  logic [ADDR_WIDTH:0]   r_issue_cnt;
  logic [ADDR_WIDTH:0]   r_recv_cnt;
  logic                  r_inflight;

  logic [DATA_WIDTH-1:0] r_mem [2];
  logic                  r_rd_ptr;
  logic                  r_wr_ptr;
  logic [1:0]            r_count;

  logic                  w_pop;
  logic                  w_push;
  logic                  w_issue;
  logic                  w_capture;
  logic                  w_room;
  logic [1:0]            w_occ;
  logic [ADDR_WIDTH-1:0] w_issue_addr;

  assign w_pop  = o_strm.valid && o_strm.ready;
  assign w_push = r_inflight;
  assign w_occ  = r_count + {1'b0, r_inflight};

  // A pop in this cycle frees a slot for a read issued in this cycle.
  assign w_room = (w_occ < 2'd2) ||
                  ((w_occ == 2'd2) && w_pop);

  assign w_issue_addr = r_base + r_issue_cnt[ADDR_WIDTH-1:0];

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_capture   = 1'b1;
          w_state_nxt = (i_length == '0) ? FINISH : READ;
        end
      end
      READ: begin
        w_issue = (r_issue_cnt < r_len) && w_room;
        // Leave as the last word is handed off so done follows it directly.
        if ((r_recv_cnt == r_len) && !r_inflight &&
            (r_count == {1'b0, w_pop}))
          w_state_nxt = FINISH;
      end
      FINISH: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_base      <= '0;
      r_len       <= '0;
      r_issue_cnt <= '0;
      r_recv_cnt  <= '0;
      r_inflight  <= 1'b0;
      r_last_addr <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_inflight <= w_issue;
      if (w_capture) begin
        r_base      <= i_base_addr;
        r_len       <= i_length;
        r_issue_cnt <= '0;
        r_recv_cnt  <= '0;
      end else begin
        if (w_issue)
          r_issue_cnt <= r_issue_cnt + 1'b1;
        if (w_push)
          r_recv_cnt <= r_recv_cnt + 1'b1;
      end
      if (w_issue)
        r_last_addr <= w_issue_addr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_ram_q;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop)
        r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  assign o_ram_addr   = w_issue ? w_issue_addr : r_last_addr;
  assign o_ram_we     = 1'b0;
  assign o_busy       = (r_state != IDLE);
  assign o_done       = (r_state == FINISH);
  assign o_strm.valid = (r_count != 2'd0);
  assign o_strm.data  = r_mem[r_rd_ptr];

endmodule

// File: doc/ram_stream_reader.md
Name: ram_stream_reader

Overview:
- Read-side client of the single-port synchronous RAM: 1-cycle registered-address read, 10-bit address, 8-bit data.
- On a start command, it sequentially reads a block of words beginning at a base address.
- It presents each word on a valid/ready output stream for downstream consumers, e.g. the SNN input-unit or UART transmit path.
- It hides the RAM read latency and absorbs backpressure with a 2-entry output buffer, sustaining 1 word/cycle when the consumer is always ready.

Parameters:
- ADDR_WIDTH, 10, RAM address width; also sets the wrap modulus 2**ADDR_WIDTH.
- DATA_WIDTH, 8, RAM and stream data width.

Ports:
- clk  input  1  System clock, 50 MHz, rising edge.
- rst  input  1  Asynchronous reset, active-high.
- start  input  1  Starts a transfer; sampled only while idle.
- base_addr  input  ADDR_WIDTH  First RAM address; captured on an accepted start.
- length  input  ADDR_WIDTH+1  Number of words, 0 to 2**ADDR_WIDTH; captured on an accepted start.
- busy  output  1  High from the cycle after an accepted start until done.
- done  output  1  One-cycle pulse when the transfer completes.
- ram_addr  output  ADDR_WIDTH  Address to the RAM addr input.
- ram_we  output  1  RAM write enable; tied 0.
- ram_q  input  DATA_WIDTH  RAM read data. Valid the cycle after ram_addr is presented.
- out_data  output  DATA_WIDTH  Stream data.
- out_valid  output  1  Stream data valid.
- out_ready  input  1  Consumer accepts out_data when out_valid && out_ready at a rising edge.

Behaviour:
- Reset values:
  - busy=0, done=0, out_valid=0, out_data=0, ram_addr=0, ram_we=0.
  - Buffer empty, in-flight flag 0, FSM=IDLE.
  - Reset mid-transfer aborts immediately. There is no done pulse and no further reads.
- FSM has three states: IDLE, READ, FINISH.
- IDLE:
  - start=1 captures base_addr and length and sets issue_cnt=0 and recv_cnt=0.
  - length=0: go to FINISH. No RAM read, no out_valid.
  - Otherwise go to READ.
- READ:
  - A read is issued in a cycle when issue_cnt<length and (buffer occupancy + in-flight + 1) <= 2, counting a pop in this same cycle as freeing a slot.
  - On issue: ram_addr = (base+issue_cnt) mod 2**ADDR_WIDTH, issue_cnt++, in-flight=1 for the next cycle.
  - The cycle after an issue, ram_q is pushed into the buffer and recv_cnt++.
  - Address wraps silently. For example, base=1022 with length=4 reads 1022, 1023, 0, 1.
  - When recv_cnt==length, the buffer is empty and no read is in flight, go to FINISH.
- FINISH: done=1 for exactly one cycle, busy=0 on the next cycle, return to IDLE.
- Output buffer:
  - 2-entry FIFO. out_valid = not empty. out_data = head entry.
  - Simultaneous push and pop is allowed at any occupancy, including when full, provided the pop frees the slot.
  - While out_valid && !out_ready, out_data and out_valid stay stable.
  - Order is strictly ascending address order, modulo wrap.
- Latency and throughput:
  - The first word's out_valid appears 2 cycles after start is sampled: capture cycle, then issue cycle, then visible.
  - With out_ready held high, one word per cycle and no bubbles after the first.
  - done asserts the cycle after the final handshake.
- Parallel start: start while busy is ignored. Captured base and length are unaffected.
- ram_addr is a don't-care when no read is issued; it holds its last value.
- Counters are ADDR_WIDTH+1 bits, so length=2**ADDR_WIDTH reads every word exactly once.

Test Plan:
- Preload RAM[i]=i[7:0]; start with base=5, length=4, out_ready=1.
  - out_data sequence is 5, 6, 7, 8 on consecutive cycles.
  - First valid occurs 2 cycles after start; done pulses once the cycle after the final handshake.
- Same transfer with out_ready toggling 1,0,0,1,0,1...
  - Same 4 values in order, none dropped or duplicated.
  - out_data stays stable while stalled; occupancy never exceeds 2.
- Wrap: base=1022, length=4 -> ram_addr issues 1022, 1023, 0, 1; out_data = 0xFE, 0xFF, 0x00, 0x01.
- Edge lengths:
  - length=0: done pulses the cycle after start; out_valid never rises; no reads issued.
  - length=1024: exactly 1024 handshakes, then done.
- Parallel start: pulse start again mid-transfer with a different base -> ignored; original sequence completes unchanged.
- Reset mid-transfer: assert rst after 2 of 6 words.
  - All outputs return to reset values asynchronously; no done pulse.
  - A subsequent start with base=0, length=2 yields 0x00, 0x01.
